stb_sample_acc: RTL and testbench
=================================

// Module: stb_sample_acc
// PURPOSE
//  Equivalent-time sampler downstream of the strobe generator. On each strobe rising edge,
//  waits a programmed delay and samples the comparator, then accumulates hits over N strobes.
//  Software sweeps delay_i across the strobe period to reconstruct the edge position and CDF.
// PARAMETERS
//  T_CNT_WIDTH    32    width of period_i / delay_i (matches strobe generator period output)
//  CNT_WIDTH      16    width of sample-count request and hit/total accumulators
//  TIMEOUT_CYCLES 2**20 max cycles in WAIT_STB without a strobe edge before err_o
// PORTS
//  clk_i        in   1            system clock
//  rst_i        in   1            reset, synchronous, active-high
//  stb_i        in   1            strobe from strobe generator (clk_i domain, no sync)
//  stb_rdy_i    in   1            strobe generator ready (period measured, strobing)
//  period_i     in   T_CNT_WIDTH  strobe period in clk_i cycles
//  cmp_i        in   1            comparator output, asynchronous
//  start_i      in   1            1-cycle pulse: start an accumulation
//  abort_i      in   1            1-cycle pulse: abandon run, return to IDLE
//  delay_i      in   T_CNT_WIDTH  sample delay after strobe edge, latched on start
//  n_samples_i  in   CNT_WIDTH    number of strobes to sample, latched on start
//  busy_o       out  1            high from accepted start until IDLE
//  done_o       out  1            1-cycle pulse: run finished (normally or with error)
//  err_o        out  1            sticky error flag of last run; cleared by next accepted start
//  hits_o       out  CNT_WIDTH    samples where synced comparator was 1
//  total_o      out  CNT_WIDTH    samples taken in this run
// BEHAVIOUR
//  Reset (sync, rst_i=1 at posedge): state=IDLE; busy_o, done_o, err_o, hits_o, total_o all 0.
//    All internal counters and the cmp_i synchronizer also clear.
//  cmp_i passes through a 2-stage synchronizer (cmp_s, 2 cycles latency).
//  Strobe edge: stb_rise = stb_i & ~stb_q, where stb_q is a 1-cycle delayed copy of stb_i.
//  FSM: IDLE, WAIT_STB, DELAY, SAMPLE, DONE.
//   IDLE: on start_i, latch D=delay_i and N=n_samples_i.
//     If stb_rdy_i=0, D>=period_i or N=0: set err_o=1, pulse done_o next cycle, stay IDLE.
//     hits_o and total_o are 0 in this case.
//     Otherwise clear err_o, hits_o and total_o, set busy_o and go to WAIT_STB.
//   WAIT_STB: on stb_rise, load dcnt=D and go to DELAY. The edge cycle is t=0.
//     Timeout: TIMEOUT_CYCLES cycles without stb_rise -> err_o=1, go to DONE.
//   DELAY: when dcnt==0 go to SAMPLE, else decrement dcnt. Sample cycle is t=D+1.
//   SAMPLE: hits_o += cmp_s; total_o += 1.
//     If new total_o==N go to DONE, else go to WAIT_STB. A fresh stb_rise is always required;
//     an edge that falls inside DELAY or SAMPLE is ignored (no queueing).
//   DONE: done_o=1 for exactly this cycle, busy_o=0 next cycle, then IDLE.
//  Outputs hits_o, total_o and err_o hold after DONE until the next accepted start.
//  stb_rdy_i low in WAIT_STB, DELAY or SAMPLE: err_o=1, go to DONE.
//    hits_o and total_o keep the partial counts.
//  abort_i in any non-IDLE state: go to IDLE next cycle, busy_o=0, no done_o, err_o unchanged.
//    abort_i has priority over all other transitions; abort_i in IDLE is ignored.
//  start_i while busy_o=1 is ignored.
//  start_i and abort_i in the same IDLE cycle: abort_i wins and start is dropped.
//  Arithmetic: hits_o<=total_o<=N, so no overflow is possible.
//    dcnt is T_CNT_WIDTH wide and unsigned; D<period_i is enforced at start.
//  rst_i mid-run: immediate return to reset values with no done_o.
// TESTING
//  1. period=100, D=10, N=8, cmp_i=1 constant -> done_o after 8th strobe, hits=8, total=8, err=0;
//     the bench checks each sample at t=11 after the edge cycle.
//  2. cmp_i high only for cycles 30..60 after each stb edge, sweep D=25,35,59,61
//     -> hits=0,N,N,0 (2-cycle sync latency accounted for).
//  3. start with D=100 when period_i=100 -> err_o=1, done_o 1 cycle later, total_o=0, busy_o stays 0.
//  4. N=16, stb_rdy_i dropped after 5 samples -> err_o=1, done_o pulse, total_o=5.
//  5. abort_i during DELAY of 3rd sample -> IDLE next cycle, no done_o, busy_o=0;
//     a new start then works normally.
//  6. stb_i stopped for TIMEOUT_CYCLES in WAIT_STB -> err_o=1, done_o;
//     assert rst_i mid-DELAY -> all outputs 0 next cycle.

Source files
------------

// File: rtl/stb_sample_acc.sv
// Equivalent-time sampler: after each strobe rising edge, waits a programmed
// delay, samples the synchronized comparator and accumulates hits over N strobes.
// Software sweeps delay_i across the strobe period to rebuild the edge CDF.
module stb_sample_acc #(
  parameter int T_CNT_WIDTH    = 32,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   stb_i,
  input  logic                   stb_rdy_i,
  input  logic [T_CNT_WIDTH-1:0] period_i,
  input  logic                   cmp_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [T_CNT_WIDTH-1:0] delay_i,
  input  logic [CNT_WIDTH-1:0]   n_samples_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [CNT_WIDTH-1:0]   hits_o,
  output logic [CNT_WIDTH-1:0]   total_o
);

  localparam int TO_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_STB,
    ST_DELAY,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t                 state_reg;
  logic [T_CNT_WIDTH-1:0] dly_reg;
  logic [T_CNT_WIDTH-1:0] dcnt_reg;
  logic [CNT_WIDTH-1:0]   n_reg;
  logic [TO_WIDTH-1:0]    to_cnt_reg;
  logic                   stb_q_reg;
  logic [1:0]             cmp_sync_reg;

  logic                   stb_rise;
  logic                   cmp_s;
  logic [CNT_WIDTH-1:0]   total_inc;
  logic [CNT_WIDTH-1:0]   hits_inc;

  assign stb_rise  = stb_i & ~stb_q_reg;
  assign cmp_s     = cmp_sync_reg[1];
  assign total_inc = total_o + CNT_WIDTH'(1);
  assign hits_inc  = hits_o + CNT_WIDTH'(cmp_s);

  // Strobe edge detector and two-stage comparator synchronizer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stb_q_reg    <= 1'b0;
      cmp_sync_reg <= 2'b00;
    end else begin
      stb_q_reg    <= stb_i;
      cmp_sync_reg <= {cmp_sync_reg[0], cmp_i};
    end
  end

  // Run control FSM with registered status outputs and accumulators.
  // The edge cycle is t=0 and SAMPLE is occupied at t=D+1: DELAY therefore
  // holds for exactly D cycles (loaded with D-1), and D=0 skips DELAY.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= ST_IDLE;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      hits_o     <= '0;
      total_o    <= '0;
      dly_reg    <= '0;
      dcnt_reg   <= '0;
      n_reg      <= '0;
      to_cnt_reg <= '0;
    end else begin
      done_o <= 1'b0;
      if (abort_i && (state_reg != ST_IDLE)) begin
        // Abort silently: no done pulse, error flag and counts untouched.
        state_reg <= ST_IDLE;
        busy_o    <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (start_i && !abort_i) begin
              dly_reg <= delay_i;
              n_reg   <= n_samples_i;
              hits_o  <= '0;
              total_o <= '0;
              if (!stb_rdy_i || (delay_i >= period_i) || (n_samples_i == '0)) begin
                // Rejected request: report immediately without leaving IDLE.
                err_o  <= 1'b1;
                done_o <= 1'b1;
              end else begin
                err_o      <= 1'b0;
                busy_o     <= 1'b1;
                to_cnt_reg <= '0;
                state_reg  <= ST_WAIT_STB;
              end
            end
          end
          ST_WAIT_STB: begin
            if (!stb_rdy_i) begin
              err_o     <= 1'b1;
              done_o    <= 1'b1;
              state_reg <= ST_DONE;
            end else if (stb_rise) begin
              if (dly_reg == '0) begin
                state_reg <= ST_SAMPLE;
              end else begin
                dcnt_reg  <= dly_reg - T_CNT_WIDTH'(1);
                state_reg <= ST_DELAY;
              end
            end else if (to_cnt_reg == TO_LAST) begin
              err_o     <= 1'b1;
              done_o    <= 1'b1;
              state_reg <= ST_DONE;
            end else begin
              to_cnt_reg <= to_cnt_reg + TO_WIDTH'(1);
            end
          end
          ST_DELAY: begin
            if (!stb_rdy_i) begin
              err_o     <= 1'b1;
              done_o    <= 1'b1;
              state_reg <= ST_DONE;
            end else if (dcnt_reg == '0) begin
              state_reg <= ST_SAMPLE;
            end else begin
              dcnt_reg <= dcnt_reg - T_CNT_WIDTH'(1);
            end
          end
          ST_SAMPLE: begin
            if (!stb_rdy_i) begin
              err_o     <= 1'b1;
              done_o    <= 1'b1;
              state_reg <= ST_DONE;
            end else begin
              hits_o  <= hits_inc;
              total_o <= total_inc;
              if (total_inc == n_reg) begin
                done_o    <= 1'b1;
                state_reg <= ST_DONE;
              end else begin
                // Edges seen during DELAY/SAMPLE are dropped; wait for a fresh one.
                to_cnt_reg <= '0;
                state_reg  <= ST_WAIT_STB;
              end
            end
          end
          ST_DONE: begin
            busy_o    <= 1'b0;
            state_reg <= ST_IDLE;
          end
          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stb_sample_acc.sv
// Scoreboard bench for stb_sample_acc: runs push expected results, a monitor
// pops and compares them on every done_o pulse.
module tb_stb_sample_acc;

  localparam int TW  = 32;
  localparam int CW  = 16;
  localparam int TO  = 200;
  localparam int PER = 100;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          stb_i;
  logic          stb_rdy_i;
  logic [TW-1:0] period_i;
  logic          cmp_i;
  logic          start_i;
  logic          abort_i;
  logic [TW-1:0] delay_i;
  logic [CW-1:0] n_samples_i;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [CW-1:0] hits_o;
  logic [CW-1:0] total_o;

  typedef struct packed {
    logic [15:0] hits;
    logic [15:0] total;
    logic        err;
    logic        busy;
  } exp_t;

  exp_t sb_q[$];

  int n_total = 0;
  int n_bad   = 0;
  int done_cnt = 0;
  int phase = 0;
  int period_cfg = PER;
  int exp_d = 0;
  bit stb_en = 1'b1;
  bit cmp_mode = 1'b0;
  bit cmp_const = 1'b1;

  always #5 clk_i = ~clk_i;

  stb_sample_acc #(
    .T_CNT_WIDTH   (TW),
    .CNT_WIDTH     (CW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .stb_i      (stb_i),
    .stb_rdy_i  (stb_rdy_i),
    .period_i   (period_i),
    .cmp_i      (cmp_i),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .delay_i    (delay_i),
    .n_samples_i(n_samples_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .hits_o     (hits_o),
    .total_o    (total_o)
  );

  function automatic exp_t mk(input int h, input int t, input bit e, input bit b);
    exp_t r;
    r.hits  = 16'(h);
    r.total = 16'(t);
    r.err   = e;
    r.busy  = b;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Strobe generator model: stb high for the first half of each period
  // (rising edge at phase 0). In window mode cmp_i is high for phases 28..58,
  // so the synchronized comparator is high for phases 30..60.
  initial begin
    stb_i = 1'b0;
    cmp_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      if (phase >= period_cfg - 1) phase = 0;
      else phase = phase + 1;
      stb_i = stb_en && (phase < period_cfg / 2);
      cmp_i = cmp_mode ? ((phase >= 28) && (phase <= 58)) : cmp_const;
    end
  end

  // Monitor: sample timing on each total_o increment, result check on done_o.
  initial begin
    logic [15:0] prev_total;
    exp_t e;
    prev_total = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_i && busy_o && (total_o == prev_total + 16'd1))
        chk("sample_phase", 32'(phase), 32'((exp_d + 2) % period_cfg));
      if (done_o) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL unexpected_done: got done_o=1 required no pending run");
        end else begin
          e = sb_q.pop_front();
          $display("run done: hits=%0d total=%0d err=%0d busy=%0d (exp %0d/%0d/%0d/%0d)",
                   hits_o, total_o, err_o, busy_o, e.hits, e.total, e.err, e.busy);
          chk("done_hits", 32'(hits_o), 32'(e.hits));
          chk("done_total", 32'(total_o), 32'(e.total));
          chk("done_err", 32'(err_o), 32'(e.err));
          chk("done_busy", 32'(busy_o), 32'(e.busy));
        end
      end
      prev_total = total_o;
    end
  end

  task automatic start_run(input int d, input int n);
    @(posedge clk_i);
    #1;
    delay_i     = TW'(d);
    n_samples_i = CW'(n);
    start_i     = 1'b1;
    exp_d       = d;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name, output int cycles);
    int start_cnt;
    start_cnt = done_cnt;
    cycles = 0;
    while ((done_cnt == start_cnt) && (cycles < budget)) begin
      @(negedge clk_i);
      #1;
      cycles++;
    end
    if (done_cnt == start_cnt) begin
      n_total++;
      n_bad++;
      $display("FAIL %s_timeout: got no done_o in %0d cycles required done_o", name, budget);
    end
  endtask

  task automatic wait_total(input int value, input int budget, input string name);
    int c;
    c = 0;
    while ((32'(total_o) != value) && (c < budget)) begin
      @(negedge clk_i);
      c++;
    end
    if (32'(total_o) != value) begin
      n_total++;
      n_bad++;
      $display("FAIL %s_wait_total: got %0d required %0d", name, total_o, value);
    end
  endtask

  task automatic wait_phase(input int value, input int budget, input string name);
    int c;
    c = 0;
    @(negedge clk_i);
    while ((phase != value) && (c < budget)) begin
      @(negedge clk_i);
      c++;
    end
    if (phase != value) begin
      n_total++;
      n_bad++;
      $display("FAIL %s_wait_phase: got %0d required %0d", name, phase, value);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog: got no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int dc;
    int ds[4];
    int hs[4];
    ds = '{25, 35, 59, 61};
    hs = '{0, 4, 4, 0};

    rst_i       = 1'b1;
    stb_rdy_i   = 1'b1;
    period_i    = TW'(PER);
    start_i     = 1'b0;
    abort_i     = 1'b0;
    delay_i     = '0;
    n_samples_i = '0;

    // Reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_hits", 32'(hits_o), 0);
    chk("rst_total", 32'(total_o), 0);
    rst_i = 1'b0;
    repeat (5) @(posedge clk_i);

    // 1: constant comparator, D=10, N=8; a start during the run is ignored
    cmp_mode = 1'b0;
    cmp_const = 1'b1;
    sb_q.push_back(mk(8, 8, 1'b0, 1'b1));
    start_run(10, 8);
    repeat (30) @(posedge clk_i);
    #1;
    delay_i = TW'(50);
    n_samples_i = CW'(2);
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    wait_done(10 * PER, "t1", cyc);
    @(negedge clk_i);
    chk("t1_busy_after", 32'(busy_o), 0);
    chk("t1_done_after", 32'(done_o), 0);

    // 2: comparator window sweep
    cmp_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(mk(hs[i], 4, 1'b0, 1'b1));
      start_run(ds[i], 4);
      wait_done(6 * PER, "t2", cyc);
    end
    cmp_mode = 1'b0;

    // 3: rejected starts (D>=period, N=0, strobe not ready)
    sb_q.push_back(mk(0, 0, 1'b1, 1'b0));
    start_run(PER, 4);
    wait_done(5, "t3_dge", cyc);
    chk("t3_done_latency", 32'(cyc), 1);
    @(negedge clk_i);
    chk("t3_busy_after", 32'(busy_o), 0);
    sb_q.push_back(mk(0, 0, 1'b1, 1'b0));
    start_run(10, 0);
    wait_done(5, "t3_n0", cyc);
    stb_rdy_i = 1'b0;
    sb_q.push_back(mk(0, 0, 1'b1, 1'b0));
    start_run(10, 4);
    wait_done(5, "t3_rdy", cyc);
    stb_rdy_i = 1'b1;

    // 4: strobe ready drops after 5 samples
    sb_q.push_back(mk(5, 5, 1'b1, 1'b1));
    start_run(10, 16);
    wait_total(5, 8 * PER, "t4");
    stb_rdy_i = 1'b0;
    wait_done(10, "t4", cyc);
    stb_rdy_i = 1'b1;

    // 5: abort during DELAY of the 3rd sample
    start_run(40, 8);
    wait_total(2, 4 * PER, "t5");
    wait_phase(20, 2 * PER, "t5");
    abort_i = 1'b1;
    dc = done_cnt;
    @(posedge clk_i);
    #1;
    abort_i = 1'b0;
    @(negedge clk_i);
    chk("t5_busy_after_abort", 32'(busy_o), 0);
    repeat (250) @(negedge clk_i);
    chk("t5_no_done", 32'(done_cnt), 32'(dc));
    chk("t5_hold_total", 32'(total_o), 2);
    chk("t5_hold_hits", 32'(hits_o), 2);
    chk("t5_hold_err", 32'(err_o), 0);
    // start and abort together in IDLE: start dropped
    @(posedge clk_i);
    #1;
    delay_i = TW'(10);
    n_samples_i = CW'(2);
    start_i = 1'b1;
    abort_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    abort_i = 1'b0;
    @(negedge clk_i);
    chk("t5_start_abort_busy", 32'(busy_o), 0);
    repeat (300) @(negedge clk_i);
    chk("t5_start_abort_no_done", 32'(done_cnt), 32'(dc));
    sb_q.push_back(mk(3, 3, 1'b0, 1'b1));
    start_run(5, 3);
    wait_done(6 * PER, "t5_restart", cyc);

    // 6: strobe stopped -> timeout, then reset mid-DELAY
    stb_en = 1'b0;
    repeat (60) @(posedge clk_i);
    sb_q.push_back(mk(0, 0, 1'b1, 1'b1));
    start_run(10, 4);
    wait_done(TO + 50, "t6_to", cyc);
    chk("t6_timeout_latency", 32'(cyc), 32'(TO + 1));
    stb_en = 1'b1;
    repeat (2 * PER) @(posedge clk_i);
    start_run(50, 4);
    wait_total(2, 4 * PER, "t6");
    wait_phase(20, 2 * PER, "t6");
    rst_i = 1'b1;
    dc = done_cnt;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("t6_rst_busy", 32'(busy_o), 0);
    chk("t6_rst_done", 32'(done_o), 0);
    chk("t6_rst_err", 32'(err_o), 0);
    chk("t6_rst_hits", 32'(hits_o), 0);
    chk("t6_rst_total", 32'(total_o), 0);
    repeat (300) @(negedge clk_i);
    chk("t6_no_done_after_rst", 32'(done_cnt), 32'(dc));

    chk("sb_empty", 32'(sb_q.size()), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
